// File: rtl/ibex_data_axil_bridge.sv
// ibex_data_axil_bridge: Ibex data port to single-beat AXI4-lite master, one transaction in flight.
// Define IBEXSIS_BRIDGE_ADDR_CHECK_EN to reject addresses outside [ADDR_LO, ADDR_HI) without touching AXI.
module ibex_data_axil_bridge #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = DW / 8,
    parameter logic [AW-1:0] ADDR_LO = 32'h4000,
    parameter logic [AW-1:0] ADDR_HI = 32'h40D8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          data_req,
    output logic          data_gnt,
    output logic          data_rvalid,
    input  logic          data_we,
    input  logic [SW-1:0] data_be,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_err,
    output logic [AW-1:0] awaddr,
    output logic          awvalid,
    input  logic          awready,
    output logic [DW-1:0] wdata,
    output logic [SW-1:0] wstrb,
    output logic          wvalid,
    input  logic          wready,
    input  logic          bvalid,
    input  logic [1:0]    bresp,
    output logic          bready,
    output logic [AW-1:0] araddr,
    output logic          arvalid,
    input  logic          arready,
    input  logic          rvalid,
    input  logic [1:0]    rresp,
    input  logic [DW-1:0] rdata,
    output logic          rready
);
`ifdef IBEXSIS_BRIDGE_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_addr;
    logic [SW-1:0] r_be;
    logic [DW-1:0] r_wdata, r_rdata;
    logic          r_err, r_awvalid, r_wvalid;
    logic          w_range_ok, w_fwd_wr, w_unused;

    // OKAY/EXOKAY differ only in bit 0; SLVERR/DECERR both set bit 1
    assign w_unused   = ^{bresp[0], rresp[0]};
    assign w_range_ok = !CHECK_EN || (data_addr >= ADDR_LO && data_addr < ADDR_HI);
    assign data_gnt   = data_req && r_state == IDLE;
    assign w_fwd_wr   = data_gnt && data_we && w_range_ok;

    assign data_rvalid = r_state == RESP;
    assign data_rdata  = r_rdata;
    assign data_err    = r_err;
    assign awaddr      = r_addr;
    assign araddr      = r_addr;
    assign wdata       = r_wdata;
    assign wstrb       = r_be;
    assign awvalid     = r_awvalid;
    assign wvalid      = r_wvalid;
    assign bready      = r_state == WR_RESP;
    assign arvalid     = r_state == RD_ADDR;
    assign rready      = r_state == RD_DATA;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:         if (data_gnt) w_next = !w_range_ok ? RESP : data_we ? WR_ADDR_DATA : RD_ADDR;
            WR_ADDR_DATA: if ((!r_awvalid || awready) && (!r_wvalid || wready)) w_next = WR_RESP;
            WR_RESP:      if (bvalid) w_next = RESP;
            RD_ADDR:      if (arready) w_next = RD_DATA;
            RD_DATA:      if (rvalid) w_next = RESP;
            default:      w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_awvalid <= w_fwd_wr || (r_awvalid && !awready);
            r_wvalid  <= w_fwd_wr || (r_wvalid && !wready);
            if (data_gnt) begin
                r_addr  <= data_addr;
                r_be    <= data_be;
                r_wdata <= data_wdata;
            end
            if (data_gnt && !w_range_ok) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
            if (r_state == WR_RESP && bvalid) begin
                r_err   <= bresp[1];
                r_rdata <= '0;
            end
            if (r_state == RD_DATA && rvalid) begin
                r_err   <= rresp[1];
                r_rdata <= rdata;
            end
        end
    end
endmodule
